fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

- Shares the single VGA framebuffer pixel-write port among three requesters:
  - 0: screen-clear engine
  - 1: trace drawer (RAM-sourced waveform)
  - 2: grid/cursor overlay
- Grants burst ownership round-robin, accepts one pixel per cycle from the owner, and presents it through a registered output stage with backpressure.
- Sits between the drawing engines and the VGA memory writer, replacing the per-state output muxing in the display sequencer.

## Interface

Parameters:
- X_W, 8, pixel X coordinate width
- Y_W, 8, pixel Y coordinate width
- COLOR_W, 12, pixel colour width
- HOLD, 16, maximum pixels accepted per grant before forced rotation (1..255)

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  3  per-requester pixel request, bit i = requester i
- last  in  3  bit i marks the current pixel of requester i as the final one of its burst
- req_x  in  3*X_W  requester i X coordinate at bits [i*X_W +: X_W]
- req_y  in  3*Y_W  requester i Y coordinate, same packing
- req_color  in  3*COLOR_W  requester i colour, same packing
- gnt  out  3  registered one-hot grant, 0 when idle
- ack  out  3  combinational; bit i high in the cycle requester i's pixel is accepted
- pix_valid  out  1  output pixel valid
- pix_x  out  X_W  output X
- pix_y  out  Y_W  output Y
- pix_color  out  COLOR_W  output colour
- pix_ready  in  1  downstream accepts the output pixel this cycle

## Operation

- States: IDLE, OWN.
- IDLE:
  - gnt = 0.
  - If any req bit is set, select the first requesting index at or after rr_ptr, scanning upward and wrapping (2→0).
  - Load gnt with that one-hot value and go to OWN.
  - Otherwise stay in IDLE.
- OWN with owner k:
  - load = req[k] & (~pix_valid | pix_ready).
  - ack[k] = load; all other ack bits are 0.
  - On load: pix_* is captured from requester k's slice and pix_valid = 1.
  - On load, burst_cnt increments.
- Release from OWN to IDLE happens in the cycle where any of these holds:
  - (a) load & last[k]
  - (b) req[k] = 0
  - (c) load and burst_cnt reaches HOLD
- On release: gnt clears, rr_ptr = k+1 mod 3, burst_cnt = 0.
- Output stage: if pix_ready & ~load, pix_valid → 0. pix_* holds its value while pix_valid & ~pix_ready.
- Requesters must hold req_x/req_y/req_color/last stable until ack is seen.
- A requester may deassert req mid-burst without ack. No pixel is lost, and the grant is released.
- Non-owner request bits are ignored while in OWN.
- Reset values:
  - state = IDLE
  - gnt = 0
  - rr_ptr = 0
  - burst_cnt = 0
  - pix_valid = 0
  - pix_x = 0, pix_y = 0, pix_color = 0
  - ack = 0 (combinational from gnt)
- Reset asserted mid-burst: all of the above clear immediately, regardless of clk. The in-flight output pixel is discarded.

## Timing

- Request → grant: req seen in IDLE at edge N gives gnt valid after edge N+1. The first ack can occur in cycle N+1.
- Accept → output: a pixel acked in cycle M appears on pix_* with pix_valid after edge M+1.
- Sustained throughput is 1 pixel/cycle while pix_ready = 1 and the owner keeps req high.
- Each release costs exactly one IDLE cycle (gnt = 0) before the next grant.
- With pix_valid = 1 and pix_ready = 0, load = 0 and ack stays low. The grant is kept unless req[k] drops.
- Simultaneous requests: the round-robin order from rr_ptr decides. After reset, requester 0 wins.

## Configuration

- Macro: FB_ARB_FIXED_PRIO_EN.
- Defined:
  - IDLE always selects the lowest requesting index (0 > 1 > 2).
  - rr_ptr is not implemented.
  - HOLD still forces release, so another requester can win if 0 has dropped.
- Undefined (default): round-robin as described above.

## Test plan

- Single requester: req=3'b010 held with 4 pixels, last on the 4th, pix_ready=1.
  - gnt=3'b010 one cycle after req.
  - ack on 4 consecutive cycles.
  - 4 pixels out, each 1 cycle after its ack.
  - Then 1 cycle of gnt=0.
- All three requesters hold req=3'b111 with 2-pixel bursts.
  - Grant order is 0,1,2,0.
  - Exactly one idle cycle between grants.
  - Under FB_ARB_FIXED_PRIO_EN the order is 0,0,0,… until requester 0 drops.
- HOLD=16, requester 2 streams 40 pixels without last.
  - Release after the 16th ack.
  - Re-granted after 1 idle cycle if it is the only requester.
  - 16/16/8 split overall.
- Backpressure: pix_ready=0 for 3 cycles mid-burst.
  - ack low during the stall, pix_* held stable.
  - On pix_ready=1, the held pixel drains and the next ack occurs the same cycle.
- Owner drops req mid-burst after 2 pixels.
  - Release the same cycle, rr_ptr advances.
  - pix_valid clears after the pending pixel drains.
- rst_n pulsed low asynchronously mid-burst.
  - gnt=0, pix_valid=0, ack=0 immediately.
  - After release, req=3'b110 grants requester 1 first (rr_ptr=0 scan).

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Purpose : shares the framebuffer pixel-write port among clear (0), trace (1) and overlay (2) engines.
// Latency : grant one cycle after a request is seen idle; an accepted pixel appears on pix_* one cycle later.
// Backpres: pix_ready low with a pixel held stalls ack; the owner keeps its grant unless it drops req.
//
// Ports   : clk/rst_n (async active-low); req/last per requester; req_x/req_y/req_color packed
//           slices [i*W +: W]; gnt registered one-hot owner; ack combinational accept strobe;
//           pix_valid/pix_x/pix_y/pix_color registered output, pix_ready from the memory writer.
// Config  : FB_ARB_FIXED_PRIO_EN defined -> fixed priority 0 > 1 > 2 (no rotation pointer);
//           undefined (default) -> round-robin starting from the requester after the last owner.
module fb_write_arbiter #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 12,
    parameter int HOLD    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           req,
    input  logic [2:0]           last,
    input  logic [3*X_W-1:0]     req_x,
    input  logic [3*Y_W-1:0]     req_y,
    input  logic [3*COLOR_W-1:0] req_color,
    output logic [2:0]           gnt,
    output logic [2:0]           ack,
    output logic                 pix_valid,
    output logic [X_W-1:0]       pix_x,
    output logic [Y_W-1:0]       pix_y,
    output logic [COLOR_W-1:0]   pix_color,
    input  logic                 pix_ready
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;
    localparam logic [7:0] HOLD_C  = 8'(HOLD);

    logic [0:0]         state_q, state_d;
    logic [2:0]         gnt_q, gnt_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic               pix_valid_q, pix_valid_d;
    logic [X_W-1:0]     pix_x_q, pix_x_d;
    logic [Y_W-1:0]     pix_y_q, pix_y_d;
    logic [COLOR_W-1:0] pix_color_q, pix_color_d;
`ifndef FB_ARB_FIXED_PRIO_EN
    logic [1:0]         rr_ptr_q, rr_ptr_d;
`endif

    logic [2:0]         pick;
    logic               own_req, own_last, load, hold_hit, release_own;
    logic [7:0]         burst_inc;
    logic [X_W-1:0]     own_x;
    logic [Y_W-1:0]     own_y;
    logic [COLOR_W-1:0] own_color;

    // Owner slice select; gnt_q is one-hot (or zero while idle, where nothing is loaded).
    always_comb begin
        own_x     = req_x[0 +: X_W];
        own_y     = req_y[0 +: Y_W];
        own_color = req_color[0 +: COLOR_W];
        case (gnt_q)
            3'b010: begin
                own_x     = req_x[X_W +: X_W];
                own_y     = req_y[Y_W +: Y_W];
                own_color = req_color[COLOR_W +: COLOR_W];
            end
            3'b100: begin
                own_x     = req_x[2*X_W +: X_W];
                own_y     = req_y[2*Y_W +: Y_W];
                own_color = req_color[2*COLOR_W +: COLOR_W];
            end
            default: ;
        endcase
    end

    // Winner selection for the next grant.
    always_comb begin
        pick = 3'b000;
`ifdef FB_ARB_FIXED_PRIO_EN
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
`else
        case (rr_ptr_q)
            2'd1: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd2: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
`endif
    end

    assign own_req   = |(req & gnt_q);
    assign own_last  = |(last & gnt_q);
    // A pixel moves only when the output register is empty or being drained this cycle.
    assign load      = (state_q == ST_OWN) && own_req && (!pix_valid_q || pix_ready);
    assign burst_inc = burst_cnt_q + 8'd1;
    assign hold_hit  = (burst_inc == HOLD_C);
    // Dropping req releases even without a pixel: nothing is in flight from the requester side.
    assign release_own = (state_q == ST_OWN) && (!own_req || (load && (own_last || hold_hit)));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        burst_cnt_d = burst_cnt_q;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
`ifndef FB_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d = 3'b000;
                if (|req) begin
                    gnt_d   = pick;
                    state_d = ST_OWN;
                end
            end
            default: begin
                if (load) burst_cnt_d = burst_inc;
                if (release_own) begin
                    state_d     = ST_IDLE;
                    gnt_d       = 3'b000;
                    burst_cnt_d = 8'd0;
`ifndef FB_ARB_FIXED_PRIO_EN
                    rr_ptr_d    = gnt_q[0] ? 2'd1 : (gnt_q[1] ? 2'd2 : 2'd0);
`endif
                end
            end
        endcase

        if (load) begin
            pix_valid_d = 1'b1;
            pix_x_d     = own_x;
            pix_y_d     = own_y;
            pix_color_d = own_color;
        end else if (pix_ready) begin
            pix_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 3'b000;
            burst_cnt_q <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
`ifndef FB_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            burst_cnt_q <= burst_cnt_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
`ifndef FB_ARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ack       = load ? gnt_q : 3'b000;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Purpose : self-checking bench for fb_write_arbiter: grant order, burst lengths, idle gaps,
//           output timing/holding under backpressure, pixel data via an expected-pixel queue.
// Requesters advance their pixel after seeing ack; pix_ready follows a small stall schedule.
module tb_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, last, gnt, ack;
    logic [23:0] req_x, req_y;
    logic [35:0] req_color;
    logic        pix_valid, pix_ready;
    logic [7:0]  pix_x, pix_y;
    logic [11:0] pix_color;

    fb_write_arbiter #(.X_W(8), .Y_W(8), .COLOR_W(12), .HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .gnt(gnt), .ack(ack), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_color(pix_color), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rem[3], blen[3], bpos[3], ser[3];
    int stall_req, stall_at, stall_left;
    bit stall_armed, chk_resume;
    logic [27:0] exp_q[$];
    int glog[$], clog[$], gaplog[$], eo[$], ec[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] pixel(input int i, input int n);
        return {8'(i * 64 + n), 8'(n * 3 + i + 1), 12'(i * 1000 + n * 7 + 5)};
    endfunction

    function automatic int idx(input logic [2:0] v);
        return v[0] ? 0 : (v[1] ? 1 : 2);
    endfunction

    task automatic apply();
        logic [27:0] p;
        for (int i = 0; i < 3; i++) begin
            p = pixel(i, ser[i]);
            req[i]  = (rem[i] > 0);
            last[i] = (blen[i] != 0) && (bpos[i] == blen[i] - 1);
            req_x[i*8 +: 8]      = p[27:20];
            req_y[i*8 +: 8]      = p[19:12];
            req_color[i*12 +: 12] = p[11:0];
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; blen[i] = 0; bpos[i] = 0; ser[i] = 0;
        end
        stall_req = -1; stall_armed = 1'b0; stall_left = 0; chk_resume = 1'b0;
        pix_ready = 1'b1;
        glog.delete(); clog.delete(); gaplog.delete(); eo.delete(); ec.delete();
        exp_q.delete();
        apply();
    endtask

    // Runs cycle by cycle: sample at negedge, update requesters just after posedge.
    task automatic run(input int max_cyc, input bit to_done);
        logic [2:0]  a, pg, prev_ack;
        logic [27:0] prev_pix, cur_pix;
        bit prev_stall, prev_rdy, done;
        int idle, cnt, n, k;
        pg = 3'b000; prev_ack = 3'b000; prev_pix = '0;
        prev_stall = 1'b0; prev_rdy = 1'b1; done = 1'b0;
        idle = 0; cnt = 0; n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
            a = ack;
            cur_pix = {pix_x, pix_y, pix_color};
            if (prev_ack != 3'b000) check("pix_valid_after_ack", 32'(pix_valid), 32'd1);
            if (prev_stall) check("pix_hold", {3'b0, pix_valid, cur_pix}, {3'b0, 1'b1, prev_pix});
            if (pix_valid && !pix_ready) check("ack_in_stall", 32'(a), 32'd0);
            if (chk_resume && !prev_rdy && pix_ready) check("ack_on_resume", 32'(a != 3'b000), 32'd1);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) check("unexpected_pixel", 32'd1, 32'd0);
                else check("pix_data", 32'(cur_pix), 32'(exp_q.pop_front()));
            end
            if (a != 3'b000) begin
                check("ack_vs_gnt", 32'(a), 32'(gnt));
                k = idx(a);
                exp_q.push_back(pixel(k, ser[k]));
            end
            if (gnt != 3'b000 && pg == 3'b000) begin
                glog.push_back(idx(gnt));
                gaplog.push_back(idle);
                cnt = 0;
            end
            if (gnt != 3'b000) begin
                if (a != 3'b000) cnt++;
                idle = 0;
            end else begin
                if (pg != 3'b000) clog.push_back(cnt);
                idle++;
            end
            pg = gnt; prev_ack = a; prev_pix = cur_pix;
            prev_stall = pix_valid && !pix_ready; prev_rdy = pix_ready;
            done = to_done && rem[0] == 0 && rem[1] == 0 && rem[2] == 0
                   && gnt == 3'b000 && !pix_valid;
            @(posedge clk);
            #1;
            if (a != 3'b000) begin
                k = idx(a);
                bpos[k] = last[k] ? 0 : bpos[k] + 1;
                ser[k]++;
                rem[k]--;
            end
            if (stall_armed && ser[stall_req] == stall_at) begin
                stall_left = 3;
                stall_armed = 1'b0;
            end
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
            end else begin
                pix_ready = 1'b1;
            end
            apply();
        end
        if (to_done) begin
            check("run_done", 32'(done), 32'd1);
            check("sb_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    task automatic end_test(input string tag);
        check({tag, "_ngrants"}, 32'(glog.size()), 32'(eo.size()));
        check({tag, "_nbursts"}, 32'(clog.size()), 32'(ec.size()));
        for (int i = 0; i < eo.size() && i < glog.size(); i++)
            check({tag, "_owner"}, 32'(glog[i]), 32'(eo[i]));
        for (int i = 0; i < ec.size() && i < clog.size(); i++)
            check({tag, "_burst_len"}, 32'(clog[i]), 32'(ec[i]));
        foreach (gaplog[i]) check({tag, "_idle_gap"}, 32'(gaplog[i]), 32'd1);
        clear_all();
    endtask

    initial begin
        rst_n = 1'b1;
        clear_all();
        #2 rst_n = 1'b0;
        #10;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'({pix_x, pix_y, pix_color}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All three requesting, 2-pixel bursts, two bursts each.
        for (int i = 0; i < 3; i++) begin rem[i] = 4; blen[i] = 2; end
        apply();
        run(200, 1'b1);
`ifdef FB_ARB_FIXED_PRIO_EN
        eo = '{0, 0, 1, 1, 2, 2};
`else
        eo = '{0, 1, 2, 0, 1, 2};
`endif
        ec = '{2, 2, 2, 2, 2, 2};
        end_test("all3");

        // Single requester, 4-pixel burst.
        rem[1] = 4; blen[1] = 4;
        apply();
        run(100, 1'b1);
        eo = '{1}; ec = '{4};
        end_test("single");

        // HOLD-forced rotation on a 40-pixel stream without last.
        rem[2] = 40;
        apply();
        run(300, 1'b1);
        eo = '{2, 2, 2}; ec = '{16, 16, 8};
        end_test("hold");

        // Backpressure: 3 stall cycles after the second pixel.
        rem[0] = 6; blen[0] = 6;
        stall_req = 0; stall_at = 2; stall_armed = 1'b1; chk_resume = 1'b1;
        apply();
        run(100, 1'b1);
        eo = '{0}; ec = '{6};
        end_test("stall");

        // Owner drops req after 2 pixels, then 1 and 2 compete.
        rem[1] = 2;
        apply();
        run(100, 1'b1);
        eo = '{1}; ec = '{2};
        end_test("drop");
        rem[1] = 1; blen[1] = 1; rem[2] = 1; blen[2] = 1;
        apply();
        run(100, 1'b1);
`ifdef FB_ARB_FIXED_PRIO_EN
        eo = '{1, 2};
`else
        eo = '{2, 1};
`endif
        ec = '{1, 1};
        end_test("after_drop");

        // Asynchronous reset in the middle of a burst.
        rem[1] = 10;
        apply();
        run(4, 1'b0);
        check("pre_rst_busy", 32'(pix_valid && gnt == 3'b010), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("async_rst_ack", 32'(ack), 32'd0);
        check("async_rst_pix_data", 32'({pix_x, pix_y, pix_color}), 32'd0);
        clear_all();
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        rem[1] = 1; blen[1] = 1; rem[2] = 1; blen[2] = 1;
        apply();
        run(100, 1'b1);
        eo = '{1, 2}; ec = '{1, 1};
        end_test("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
